// File: rtl/cpu_pkg.sv
// Shared constants for the forwarding pipeline: operand-select codes and
// default datapath/register-index widths.
package cpu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RW_DEF   = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/fwd_cmp.sv
// Per-operand forwarding comparator: picks the youngest in-flight writer of rs_i.
module fwd_cmp
  import cpu_pkg::*;
#(
  parameter int unsigned RW = RW_DEF
) (
  input  logic [RW-1:0] rs_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic          exmem_regwrite_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic          memwb_regwrite_i,
  output logic [1:0]    sel_o,
  output logic          exmem_hit_o
);

  logic memwb_hit;

  // x0 is hardwired to zero, so a write to it never produces a forward.
  assign exmem_hit_o = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign memwb_hit   = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (exmem_hit_o) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/forward_pipe.sv
// EX/MEM and MEM/WB pipeline registers with operand-forwarding selects and
// load-use detection for the instruction currently in EX.
module forward_pipe
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RW   = RW_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            bubble_i,
  input  logic [RW-1:0]   ex_rd_i,
  input  logic            ex_regwrite_i,
  input  logic            ex_memtoreg_i,
  input  logic [XLEN-1:0] ex_alu_i,
  input  logic [RW-1:0]   ex_rs1_i,
  input  logic [RW-1:0]   ex_rs2_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic [1:0]      fwd_a_o,
  output logic [1:0]      fwd_b_o,
  output logic [XLEN-1:0] exmem_data_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [RW-1:0]   wb_rd_o,
  output logic            wb_regwrite_o,
  output logic            load_use_o
);

  logic [RW-1:0]   exmem_rd_q, exmem_rd_d;
  logic            exmem_regwrite_q, exmem_regwrite_d;
  logic            exmem_memtoreg_q, exmem_memtoreg_d;
  logic [XLEN-1:0] exmem_alu_q, exmem_alu_d;
  logic [RW-1:0]   memwb_rd_q, memwb_rd_d;
  logic            memwb_regwrite_q, memwb_regwrite_d;
  logic [XLEN-1:0] memwb_data_q, memwb_data_d;

  logic hit_a, hit_b;

  // Stall overrides bubble; a bubble inserts an all-zero NOP into EX/MEM.
  always_comb begin
    exmem_rd_d       = exmem_rd_q;
    exmem_regwrite_d = exmem_regwrite_q;
    exmem_memtoreg_d = exmem_memtoreg_q;
    exmem_alu_d      = exmem_alu_q;
    memwb_rd_d       = memwb_rd_q;
    memwb_regwrite_d = memwb_regwrite_q;
    memwb_data_d     = memwb_data_q;
    if (!stall_i) begin
      memwb_rd_d       = exmem_rd_q;
      memwb_regwrite_d = exmem_regwrite_q;
      memwb_data_d     = exmem_memtoreg_q ? mem_rdata_i : exmem_alu_q;
      if (bubble_i) begin
        exmem_rd_d       = '0;
        exmem_regwrite_d = 1'b0;
        exmem_memtoreg_d = 1'b0;
        exmem_alu_d      = '0;
      end else begin
        exmem_rd_d       = ex_rd_i;
        exmem_regwrite_d = ex_regwrite_i;
        exmem_memtoreg_d = ex_memtoreg_i;
        exmem_alu_d      = ex_alu_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      exmem_rd_q       <= '0;
      exmem_regwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_alu_q      <= '0;
      memwb_rd_q       <= '0;
      memwb_regwrite_q <= 1'b0;
      memwb_data_q     <= '0;
    end else begin
      exmem_rd_q       <= exmem_rd_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      exmem_memtoreg_q <= exmem_memtoreg_d;
      exmem_alu_q      <= exmem_alu_d;
      memwb_rd_q       <= memwb_rd_d;
      memwb_regwrite_q <= memwb_regwrite_d;
      memwb_data_q     <= memwb_data_d;
    end
  end

  fwd_cmp #(
    .RW(RW)
  ) u_fwd_a (
    .rs_i            (ex_rs1_i),
    .exmem_rd_i      (exmem_rd_q),
    .exmem_regwrite_i(exmem_regwrite_q),
    .memwb_rd_i      (memwb_rd_q),
    .memwb_regwrite_i(memwb_regwrite_q),
    .sel_o           (fwd_a_o),
    .exmem_hit_o     (hit_a)
  );

  fwd_cmp #(
    .RW(RW)
  ) u_fwd_b (
    .rs_i            (ex_rs2_i),
    .exmem_rd_i      (exmem_rd_q),
    .exmem_regwrite_i(exmem_regwrite_q),
    .memwb_rd_i      (memwb_rd_q),
    .memwb_regwrite_i(memwb_regwrite_q),
    .sel_o           (fwd_b_o),
    .exmem_hit_o     (hit_b)
  );

  // Load data is not ready until MEM completes; the hazard unit must stall.
  assign load_use_o    = exmem_memtoreg_q && (hit_a || hit_b);

  assign exmem_data_o  = exmem_alu_q;
  assign wb_data_o     = memwb_data_q;
  assign wb_rd_o       = memwb_rd_q;
  assign wb_regwrite_o = memwb_regwrite_q;

endmodule

// File: doc/forward_pipe.md
FORWARD_PIPE -- requirements
Module: forward_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter RW, default 5: register-index width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset; synchronous, active-low.
REQ-005 SHALL have port stall_i, input, 1: hold both pipeline stages.
REQ-006 SHALL have port bubble_i, input, 1: load a NOP into EX/MEM instead of the EX inputs.
REQ-007 SHALL have ports ex_rd_i (input, RW), ex_regwrite_i (input, 1), ex_memtoreg_i (input, 1) and ex_alu_i (input, XLEN): EX-stage destination, write enable, load flag and ALU result.
REQ-008 SHALL have ports ex_rs1_i and ex_rs2_i, input, RW each: source registers of the instruction currently in EX.
REQ-009 SHALL have port mem_rdata_i, input, XLEN: data-memory read data for the EX/MEM instruction, valid in the same cycle.
REQ-010 SHALL have ports fwd_a_o and fwd_b_o, output, 2 each: operand-select codes for the EX-stage operand muxes.
REQ-011 SHALL have port exmem_data_o, output, XLEN: registered EX/MEM ALU result.
REQ-012 SHALL have port wb_data_o, output, XLEN: registered MEM/WB write-back value.
REQ-013 SHALL have ports wb_rd_o (output, RW) and wb_regwrite_o (output, 1): register-file write port.
REQ-014 SHALL have port load_use_o, output, 1: an EX/MEM load matches an EX source.

Function
REQ-015 SHALL, when stall_i=0 and bubble_i=0, capture ex_rd_i, ex_regwrite_i, ex_memtoreg_i and ex_alu_i into EX/MEM at each edge.
REQ-016 SHALL, when stall_i=0 and bubble_i=1, load EX/MEM with rd=0, regwrite=0, memtoreg=0 and alu=0.
REQ-017 SHALL, when stall_i=0, capture into MEM/WB: rd, regwrite, and data = (EX/MEM memtoreg ? mem_rdata_i : EX/MEM alu).
REQ-018 SHALL, when stall_i=1, hold both stages unchanged; stall_i overrides bubble_i.
REQ-019 SHALL give every stage one cycle of latency: EX input to exmem_data_o takes 1 edge; to wb_data_o takes 2 edges.
REQ-020 SHALL compute fwd_a_o combinationally from ex_rs1_i and the registered stage state, with EX/MEM priority:
- 2'b10 when EX/MEM regwrite=1, EX/MEM rd!=0 and EX/MEM rd==rs1;
- otherwise 2'b01 when MEM/WB regwrite=1, MEM/WB rd!=0 and MEM/WB rd==rs1;
- otherwise 2'b00.
REQ-021 SHALL compute fwd_b_o identically from ex_rs2_i.
REQ-022 SHALL never drive code 2'b11.
REQ-023 SHALL never forward for register x0, even when regwrite=1.
REQ-024 SHALL assert load_use_o combinationally when EX/MEM memtoreg=1, EX/MEM regwrite=1, EX/MEM rd!=0, and rd equals rs1 or rs2; the select code remains 2'b10 and the hazard unit stalls.
REQ-025 SHALL drive wb_rd_o, wb_regwrite_o and wb_data_o directly from the MEM/WB registers.

Reset
REQ-026 SHALL, when rst_i=0 at an edge, clear all EX/MEM and MEM/WB fields to 0, regardless of stall_i and bubble_i.
REQ-027 SHALL, during and after reset, output fwd_a_o=fwd_b_o=2'b00, load_use_o=0, wb_regwrite_o=0, exmem_data_o=0 and wb_data_o=0.
REQ-028 SHALL, when reset is asserted mid-stream, discard all in-flight instructions; no register-file write occurs on the following cycle.

Structure
REQ-029 SHALL place the constants FWD_RF=2'b00, FWD_WB=2'b01 and FWD_EXMEM=2'b10, plus the XLEN/RW defaults, in shared package cpu_pkg.
REQ-030 SHALL implement the per-operand comparison in sub-module fwd_cmp and instantiate it twice (operand A and operand B).
REQ-031 SHALL contain no latches; every combinational output SHALL be fully assigned.

Verification
REQ-032 SHALL cover EX forward: ex_rd_i=5, regwrite=1, alu=0x1234 for 1 cycle, then rs1=5 -> fwd_a_o=10, exmem_data_o=0x1234.
REQ-033 SHALL cover WB forward with priority: x7 written with 0xAA, then x7 written with 0xBB in the next cycle, then rs2=7 -> fwd_b_o=10 (0xBB); one bubble later -> fwd_b_o=01, wb_data_o=0xBB.
REQ-034 SHALL cover x0: rd=0, regwrite=1, rs1=rs2=0 -> fwd_a_o=fwd_b_o=00 in every cycle.
REQ-035 SHALL cover load: memtoreg=1, rd=3, mem_rdata_i=0xDEAD, rs1=3 -> load_use_o=1; after the next edge wb_data_o=0xDEAD and wb_rd_o=3.
REQ-036 SHALL cover stall/bubble: stall_i=1 and bubble_i=1 for 3 cycles -> all outputs constant; then bubble only -> EX/MEM regwrite=0 and fwd codes 00 for that slot.
REQ-037 SHALL cover reset mid-operation: rst_i=0 for 1 edge with a valid write pending -> wb_regwrite_o=0 on the next cycle, all outputs 0.
